// File: rtl/alu_pkg.sv
// Shared ALU control codes and multiply-unit FSM encoding for the EX stage.
package alu_pkg;

    localparam logic [4:0] ALU_ADD  = 5'b00010;
    localparam logic [4:0] ALU_SUB  = 5'b00110;
    localparam logic [4:0] ALU_AND  = 5'b00000;
    localparam logic [4:0] ALU_OR   = 5'b00001;
    localparam logic [4:0] ALU_SLT  = 5'b00111;
    localparam logic [4:0] ALU_MULT = 5'b01001;
    localparam logic [4:0] ALU_MUL  = 5'b10001;
    localparam logic [4:0] ALU_MFLO = 5'b10010;
    // The ALU decoder emits this code for func 6'b010000.
    localparam logic [4:0] ALU_MFHI = 5'b10011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    function automatic logic is_mult_start(input logic [4:0] code);
        return (code == ALU_MULT) || (code == ALU_MUL);
    endfunction

    function automatic logic is_mult_read(input logic [4:0] code);
        return (code == ALU_MFLO) || (code == ALU_MFHI);
    endfunction

endpackage

// File: rtl/mult_datapath.sv
// Unsigned radix-2 shift-add core on operand magnitudes; the sign is reapplied
// combinationally on the finished product.
module mult_datapath #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               step,
    input  logic [WIDTH-1:0]   srca,
    input  logic [WIDTH-1:0]   srcb,
    output logic [2*WIDTH-1:0] product,
    output logic               cnt_last
);

    logic [WIDTH-1:0]   ops     [2];
    logic [WIDTH-1:0]   abs_ops [2];
    logic [2*WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               sign_reg;

    assign ops[0] = srca;
    assign ops[1] = srcb;

    // Two's-complement negate; the most negative value maps onto itself,
    // which is the correct magnitude when read as unsigned.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_abs
            assign abs_ops[gi] = ops[gi][WIDTH-1] ? (~ops[gi] + WIDTH'(1)) : ops[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            sign_reg   <= 1'b0;
        end else if (start) begin
            mcand_reg  <= {{WIDTH{1'b0}}, abs_ops[0]};
            mplier_reg <= abs_ops[1];
            acc_reg    <= '0;
            cnt_reg    <= '0;
            sign_reg   <= srca[WIDTH-1] ^ srcb[WIDTH-1];
        end else if (step) begin
            acc_reg    <= acc_reg + (mplier_reg[0] ? mcand_reg : '0);
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg + CNT_W'(1);
        end
    end

    assign cnt_last = (cnt_reg == CNT_W'(WIDTH - 1));
    assign product  = sign_reg ? (~acc_reg + (2*WIDTH)'(1)) : acc_reg;

endmodule

// File: rtl/mult_unit.sv
// EX-stage multi-cycle signed multiplier: owns HI/LO, sequences MULT/MUL,
// serves MFLO/MFHI and stalls the pipeline while a multiply is in flight.
module mult_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       alucn,
    input  logic             ex_valid,
    input  logic             flush,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mult_state_t        state_reg, state_next;
    logic               op_mul_reg, op_mul_next;
    logic [WIDTH-1:0]   hi_reg, hi_next;
    logic [WIDTH-1:0]   lo_reg, lo_next;
    logic [WIDTH-1:0]   result_reg;
    logic               start, step, cnt_last;
    logic [2*WIDTH-1:0] product;

    mult_datapath #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_datapath (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .step     (step),
        .srca     (srca),
        .srcb     (srcb),
        .product  (product),
        .cnt_last (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            op_mul_reg <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            op_mul_reg <= op_mul_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
            if (result_valid) begin
                result_reg <= result;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        op_mul_next  = op_mul_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        start        = 1'b0;
        step         = 1'b0;
        result       = result_reg;
        result_valid = 1'b0;
        case (state_reg)
            IDLE: begin
                if (ex_valid && is_mult_read(alucn)) begin
                    result       = (alucn == ALU_MFHI) ? hi_reg : lo_reg;
                    result_valid = 1'b1;
                end
                if (ex_valid && is_mult_start(alucn)) begin
                    start       = 1'b1;
                    op_mul_next = (alucn == ALU_MUL);
                    state_next  = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_next = IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt_last) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                // The architectural write commits even if a flush arrives now.
                hi_next = product[2*WIDTH-1:WIDTH];
                lo_next = product[WIDTH-1:0];
                if (op_mul_reg) begin
                    result       = product[WIDTH-1:0];
                    result_valid = 1'b1;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A MUL must write rd, so it stalls from its accept cycle; anything touching
    // the unit while busy waits for IDLE.
    always_comb begin
        stall = 1'b0;
        if (ex_valid) begin
            if (state_reg == IDLE) begin
                stall = (alucn == ALU_MUL);
            end else begin
                stall = is_mult_start(alucn) || is_mult_read(alucn);
            end
        end
    end

    assign hi = hi_reg;
    assign lo = lo_reg;

endmodule
